// File: rtl/up_down_counter_if.sv
// rtl/up_down_counter_if.sv - control and status bundle for up_down_counter
interface up_down_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output en, up_down, load, load_value,
    input  count, tc
  );

  modport slave (
    input  en, up_down, load, load_value,
    output count, tc
  );
endinterface

// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - up/down counter with load and registered wrap flag
// Define UP_DOWN_COUNTER_SATURATE_EN to saturate at the boundaries instead of wrapping.
module up_down_counter #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  up_down_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] MAX  = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = bus.load_value;
    end else if (bus.en) begin
      if (bus.up_down) begin
        if (count_q == MAX) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
          count_d = MAX;
`else
          count_d = ZERO;
`endif
          tc_d = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == ZERO) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
          count_d = ZERO;
`else
          count_d = MAX;
`endif
          tc_d = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // tc is registered so it lines up with count showing the boundary value
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= RESET_VALUE;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_up_down_counter.sv
// tb/tb_up_down_counter.sv - directed self-checking bench for up_down_counter
module tb_up_down_counter;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  up_down_counter_if #(.WIDTH(4)) bus4 ();
  up_down_counter_if #(.WIDTH(8)) bus8 ();

  up_down_counter #(.WIDTH(4), .RESET_VALUE(4'h0)) dut4 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus4.slave)
  );

  up_down_counter #(.WIDTH(8), .RESET_VALUE(8'hFE)) dut8 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive4(input logic ld, input logic [3:0] lv, input logic e, input logic ud);
    bus4.load       = ld;
    bus4.load_value = lv;
    bus4.en         = e;
    bus4.up_down    = ud;
  endtask

  // apply one set of inputs, clock once, then check count/tc 1 time unit after the edge
  task automatic edge4(input string tag, input logic ld, input logic [3:0] lv, input logic e,
                       input logic ud, input logic [3:0] exp_cnt, input logic exp_tc);
    drive4(ld, lv, e, ud);
    @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(bus4.count), 32'(exp_cnt));
    check({tag, "_tc"},    32'(bus4.tc),    32'(exp_tc));
  endtask

  initial begin
    reset = 1'b0;
    drive4(1'b0, 4'h0, 1'b0, 1'b0);
    bus8.load = 1'b0; bus8.load_value = 8'h00; bus8.en = 1'b0; bus8.up_down = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count4", 32'(bus4.count), 32'h0);
    check("rst_tc4",    32'(bus4.tc),    32'h0);
    check("rst_count8", 32'(bus8.count), 32'hFE);
    check("rst_tc8",    32'(bus8.tc),    32'h0);

    // WIDTH=8 instance counts up from its reset value across the wrap
    reset = 1'b1;
    bus8.en = 1'b1; bus8.up_down = 1'b1;
    @(posedge clk); #1;
    check("w8_e1_count", 32'(bus8.count), 32'hFF);
    check("w8_e1_tc",    32'(bus8.tc),    32'h0);
    @(posedge clk); #1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    check("w8_e2_count", 32'(bus8.count), 32'hFF);
`else
    check("w8_e2_count", 32'(bus8.count), 32'h00);
`endif
    check("w8_e2_tc",    32'(bus8.tc),    32'h1);
    @(posedge clk); #1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    check("w8_e3_count", 32'(bus8.count), 32'hFF);
    check("w8_e3_tc",    32'(bus8.tc),    32'h1);
`else
    check("w8_e3_count", 32'(bus8.count), 32'h01);
    check("w8_e3_tc",    32'(bus8.tc),    32'h0);
`endif
    bus8.en = 1'b0;
    check("w8_hold_count4", 32'(bus4.count), 32'h0);

    // asynchronous reset mid-count
    edge4("ld7", 1'b1, 4'h7, 1'b0, 1'b0, 4'h7, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_count", 32'(bus4.count), 32'h0);
    check("async_rst_tc",    32'(bus4.tc),    32'h0);
    check("async_rst_count8", 32'(bus8.count), 32'hFE);
    #2;
    reset = 1'b1;
    edge4("rel1", 1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0);
    edge4("rel2", 1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0);
    edge4("rel3", 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 1'b0);

    // up boundary
    edge4("upld", 1'b1, 4'hE, 1'b0, 1'b0, 4'hE, 1'b0);
    edge4("up1",  1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    edge4("up2",  1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b1);
    edge4("up3",  1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b1);
`else
    edge4("up2",  1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);
    edge4("up3",  1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0);
`endif

    // down boundary
    edge4("dnld", 1'b1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0);
    edge4("dn1",  1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    edge4("dn2",  1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    edge4("dn3",  1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
`else
    edge4("dn2",  1'b0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b1);
    edge4("dn3",  1'b0, 4'h0, 1'b1, 1'b0, 4'hE, 1'b0);
`endif

    // direction toggles with no bubble
    edge4("dirld", 1'b1, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0);
    edge4("dir1",  1'b0, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0);
    edge4("dir2",  1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 1'b0);
    edge4("dir3",  1'b0, 4'h0, 1'b1, 1'b0, 4'h6, 1'b0);
    edge4("dir4",  1'b0, 4'h0, 1'b1, 1'b0, 4'h5, 1'b0);
    edge4("dir5",  1'b0, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0);

    // load beats enable, then hold
    edge4("prild", 1'b1, 4'h9, 1'b0, 1'b0, 4'h9, 1'b0);
    edge4("pri",   1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 4; i++)
      edge4($sformatf("hold%0d", i), 1'b0, 4'hA, 1'b0, 1'b1, 4'h3, 1'b0);

    // load clears a pending tc
    edge4("tcld",  1'b1, 4'hF, 1'b0, 1'b0, 4'hF, 1'b0);
    edge4("tcclr", 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
- Parameterised synchronous binary up/down counter with a single clock and an asynchronous active-low reset.
- Provides count enable, synchronous parallel load, direction control and a registered terminal-count/wrap indication.
- Used as a general-purpose event/position counter in datapath and control blocks; default width 4 bits.

Parameters:
- WIDTH, 4, counter width in bits (legal ≥ 2).
- RESET_VALUE, 0, value loaded into count on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; 0 = reset asserted, 1 = run.
- en  input  1  count enable; 1 = count this cycle.
- up_down  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value captured when load=1.
- count  output  WIDTH  current counter value (registered).
- tc  output  1  registered wrap/terminal flag; pulses one cycle when the counter passes a boundary.

Behaviour:
- Reset (reset=0, any time, independent of clk):
  - count=RESET_VALUE, tc=0 immediately.
  - Held while reset=0.
  - Release is synchronous in effect: the first update occurs on the first rising clk edge with reset=1.
- Priority on each rising clk edge with reset=1: load > en > hold.
- load=1:
  - count <= load_value, tc <= 0, regardless of en/up_down.
- load=0, en=1, up_down=1:
  - count <= count+1 mod 2^WIDTH.
  - All-ones wraps to 0 with tc <= 1.
- load=0, en=1, up_down=0:
  - count <= count-1 mod 2^WIDTH.
  - 0 wraps to all-ones with tc <= 1.
- load=0, en=0:
  - count holds, tc <= 0.
- tc:
  - Asserted in the cycle after the wrapping edge, i.e. coincident with count showing the wrapped value.
  - Deasserted on the next edge unless another wrap occurs.
- Direction change: takes effect on the next enabled edge; no bubble, no extra latency.
- Latency: 1 clk from input sampling to count/tc update.
- Outputs are pure flops; no combinational path from inputs to outputs.
- All arithmetic is unsigned WIDTH-bit; no X propagation from an unused load_value when load=0.

Optional Feature:
- Macro: UP_DOWN_COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping. Up at all-ones holds all-ones; down at 0 holds 0.
  - tc <= 1 on every enabled edge attempted at the boundary, i.e. a sticky pulse each cycle while pinned.
  - Load is unaffected.
- Undefined: modular wrap-around as described in Behaviour (default build).

Test Plan:
- Reset mid-count: count=7, drive reset=0 between clock edges -> count=0 and tc=0 immediately (asynchronously). Release reset, en=1, up_down=1 -> count 1, 2, 3 on successive edges.
- Up wrap: load 4'hE, then en=1, up_down=1 for 3 edges -> count F, 0, 1; tc=1 only while count=0.
  - With UP_DOWN_COUNTER_SATURATE_EN: F, F, F with tc=1 on the 2nd and 3rd edges.
- Down wrap: load 4'h1, en=1, up_down=0 for 3 edges -> count 0, F, E; tc=1 only while count=F.
  - With UP_DOWN_COUNTER_SATURATE_EN: 0, 0, 0.
- Direction toggle: from count=5 with en=1, apply up_down=1,1,0,0,1 on consecutive edges -> count 6, 7, 6, 5, 6; tc stays 0.
- Priority/hold: count=9 with load=1, load_value=3, en=1, up_down=1 -> count=3. Then en=0 for 4 edges -> count stays 3, tc=0.
- Width parameter: WIDTH=8, RESET_VALUE=8'hFE; after reset release, en=1, up_down=1 -> FF, 00 (tc=1), 01.
